// File: rtl/score_bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_bcd_display_pkg
// Purpose  : Shared definitions for the BCD score board: digit width, the
//            command FSM state encoding and an all-nines constant builder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package score_bcd_display_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Saturation value for a score of the given digit count, built at the
    // widest supported size; callers keep the low 4*digits bits.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] bcd_all_nines(input int digits);
        logic [BCD_W*MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                v[i*BCD_W +: BCD_W] = 4'd9;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module   : digit_glyph_rom
// Purpose  : Ten GLYPH_W x GLYPH_H one-bit digit glyphs drawn as seven-segment
//            shapes, read synchronously with one cycle of latency.
// Ports    : clk, reset_n - clock and async active-low reset
//            i_addr      - glyph*W*H + y*W + x
//            o_dout      - registered pixel bit for i_addr
// Revision : 1.0 - initial release
// ============================================================================
module digit_glyph_rom #(
    parameter int GLYPH_W = 60,
    parameter int GLYPH_H = 80,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_dout
);

    localparam int C_PIX = GLYPH_W * GLYPH_H;
    localparam int C_T   = GLYPH_W / 6;   // stroke thickness
    localparam int C_HM  = GLYPH_H / 2;   // vertical middle

    int         w_a;
    int         w_v;
    int         w_r;
    int         w_x;
    int         w_y;
    logic [6:0] w_seg;   // {g,f,e,d,c,b,a}
    logic [6:0] w_reg;   // pixel lies inside each segment's area
    logic       w_bit;
    logic       r_dout;

    always_comb begin
        w_a = int'(i_addr);
        w_v = w_a / C_PIX;
        w_r = w_a - w_v * C_PIX;
        w_y = w_r / GLYPH_W;
        w_x = w_r - w_y * GLYPH_W;

        case (w_v)
            0:       w_seg = 7'b0111111;
            1:       w_seg = 7'b0000110;
            2:       w_seg = 7'b1011011;
            3:       w_seg = 7'b1001111;
            4:       w_seg = 7'b1100110;
            5:       w_seg = 7'b1101101;
            6:       w_seg = 7'b1111101;
            7:       w_seg = 7'b0000111;
            8:       w_seg = 7'b1111111;
            9:       w_seg = 7'b1101111;
            default: w_seg = 7'b0000000;
        endcase

        w_reg[0] = (w_y < C_T) && (w_x >= C_T) && (w_x < GLYPH_W - C_T);
        w_reg[1] = (w_x >= GLYPH_W - C_T) && (w_y >= C_T) && (w_y < C_HM);
        w_reg[2] = (w_x >= GLYPH_W - C_T) && (w_y >= C_HM) && (w_y < GLYPH_H - C_T);
        w_reg[3] = (w_y >= GLYPH_H - C_T) && (w_x >= C_T) && (w_x < GLYPH_W - C_T);
        w_reg[4] = (w_x < C_T) && (w_y >= C_HM) && (w_y < GLYPH_H - C_T);
        w_reg[5] = (w_x < C_T) && (w_y >= C_T) && (w_y < C_HM);
        w_reg[6] = (w_y >= C_HM - C_T/2) && (w_y < C_HM + C_T/2) &&
                   (w_x >= C_T) && (w_x < GLYPH_W - C_T);

        w_bit = |(w_seg & w_reg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= 1'b0;
        end else begin
            r_dout <= w_bit;
        end
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/score_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : score_bcd_display
// Purpose  : N-digit BCD score / high score with digit-serial add/subtract
//            (saturating on overflow, sticky game-over on underflow) and a
//            pixel fill flag for the on-screen readout.
// Ports    : clk, reset_n          - clock, async active-low reset
//            cmd_valid/cmd_ready  - command handshake
//            cmd_sub, cmd_amount  - subtract flag, 0..9 points (clamped)
//            game_clr             - clears score and gameover
//            show_hi              - readout shows hi_score instead of score
//            score, hi_score      - BCD values, digit 0 in the LSBs
//            gameover             - sticky underflow flag
//            x_p, y_p             - current pixel
//            isFilled             - current pixel lies on a lit glyph
// Revision : 1.0 - initial release
// ============================================================================
module score_bcd_display
    import score_bcd_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int GLYPH_W  = 60,
    parameter int GLYPH_H  = 80,
    parameter int X_ORIGIN = 560,
    parameter int Y_ORIGIN = 0,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 600
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_sub,
    input  logic [3:0]              cmd_amount,
    input  logic                    game_clr,
    input  logic                    show_hi,
    output logic [BCD_W*DIGITS-1:0] score,
    output logic [BCD_W*DIGITS-1:0] hi_score,
    output logic                    gameover,
    input  logic [11:0]             x_p,
    input  logic [11:0]             y_p,
    output logic                    isFilled
);

    localparam int C_SW     = BCD_W * DIGITS;
    localparam int C_IDX_W  = $clog2(DIGITS);
    localparam int C_PIX    = GLYPH_W * GLYPH_H;
    localparam int C_ADDR_W = $clog2(10 * C_PIX);
    localparam logic [BCD_W*MAX_DIGITS-1:0] C_NINES_FULL = bcd_all_nines(DIGITS);
    localparam logic [C_SW-1:0]             C_NINES      = C_NINES_FULL[C_SW-1:0];

    // ---------------- command FSM ----------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_cmd_ready;
    logic               w_accept;
    logic [C_SW-1:0]    r_score;
    logic [C_SW-1:0]    r_hi;
    logic               r_gameover;
    logic [C_SW-1:0]    r_work;
    logic               r_sub;
    logic [3:0]         r_amt;
    logic [C_IDX_W-1:0] r_idx;
    logic               r_carry;   // carry for add, borrow for subtract

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = !game_clr;
                if (cmd_valid && !game_clr) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_idx == C_IDX_W'(DIGITS - 1)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (game_clr) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One BCD digit per CALC cycle; the amount only enters at digit 0.
    logic [3:0] w_s_dig;
    logic [3:0] w_a;
    logic [4:0] w_sum;
    logic [4:0] w_sum_adj;
    logic [4:0] w_diff;
    logic [3:0] w_dig;
    logic       w_carry_nxt;

    always_comb begin
        w_s_dig     = r_work[int'(r_idx)*BCD_W +: BCD_W];
        w_a         = (r_idx == '0) ? r_amt : 4'd0;
        w_sum       = {1'b0, w_s_dig} + {1'b0, w_a} + {4'd0, r_carry};
        w_sum_adj   = w_sum - 5'd10;
        w_diff      = {1'b0, w_s_dig} - {1'b0, w_a} - {4'd0, r_carry};
        w_dig       = w_sum[3:0];
        w_carry_nxt = 1'b0;
        if (r_sub) begin
            w_dig = w_diff[3:0];
            if (w_diff[4]) begin
                w_dig       = w_diff[3:0] + 4'd10;
                w_carry_nxt = 1'b1;
            end
        end else if (w_sum > 5'd9) begin
            w_dig       = w_sum_adj[3:0];
            w_carry_nxt = 1'b1;
        end
    end

    logic [C_SW-1:0] w_new_score;
    logic            w_gameover_nxt;

    always_comb begin
        w_new_score    = r_work;
        w_gameover_nxt = r_gameover;
        if (r_gameover) begin
            w_new_score = r_score;      // commands are ignored after game over
        end else if (r_carry && !r_sub) begin
            w_new_score = C_NINES;
        end else if (r_carry && r_sub) begin
            w_new_score    = '0;
            w_gameover_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_score    <= '0;
            r_hi       <= '0;
            r_gameover <= 1'b0;
            r_work     <= '0;
            r_sub      <= 1'b0;
            r_amt      <= 4'd0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
        end else if (game_clr) begin
            r_score    <= '0;
            r_gameover <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sub   <= cmd_sub;
                        r_amt   <= (cmd_amount > 4'd9) ? 4'd9 : cmd_amount;
                        r_work  <= r_score;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_work[int'(r_idx)*BCD_W +: BCD_W] <= w_dig;
                    r_carry <= w_carry_nxt;
                    r_idx   <= r_idx + 1'b1;
                end
                ST_COMMIT: begin
                    r_score    <= w_new_score;
                    r_gameover <= w_gameover_nxt;
                    if (w_new_score > r_hi) begin
                        r_hi <= w_new_score;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign score     = r_score;
    assign hi_score  = r_hi;
    assign gameover  = r_gameover;

    // ---------------- readout ----------------
    // Everything is computed for the next pixel so the ROM latency lines up
    // with the pixel the mixer is drawing when isFilled is consumed.
    logic [11:0]         w_nx;
    logic [11:0]         w_ny;
    logic [C_SW-1:0]     w_disp;
    logic                w_hit_x;
    logic                w_in_y;
    logic [C_IDX_W-1:0]  w_slot;
    int                  w_xrel;
    int                  w_yrel;
    logic                w_zero_acc;
    logic                w_blank;
    logic [3:0]          w_v;
    int                  w_addr_i;
    logic [C_ADDR_W-1:0] w_rom_addr;
    logic                w_rom_dout;
    logic                r_in_slot;
    logic                r_blank;

    always_comb begin
        w_nx = x_p + 12'd1;
        w_ny = y_p;
        if (x_p >= 12'(H_TOTAL - 1)) begin
            w_nx = '0;
            w_ny = (y_p >= 12'(V_TOTAL - 1)) ? 12'd0 : y_p + 12'd1;
        end
    end

    always_comb begin
        w_disp  = show_hi ? r_hi : r_score;
        w_hit_x = 1'b0;
        w_slot  = '0;
        w_xrel  = 0;
        for (int j = 0; j < DIGITS; j++) begin
            if (int'(w_nx) >= X_ORIGIN + j*GLYPH_W &&
                int'(w_nx) <  X_ORIGIN + (j+1)*GLYPH_W) begin
                w_hit_x = 1'b1;
                w_slot  = C_IDX_W'(DIGITS - 1 - j);
                w_xrel  = int'(w_nx) - X_ORIGIN - j*GLYPH_W;
            end
        end
        w_in_y = (int'(w_ny) >= Y_ORIGIN) && (int'(w_ny) < Y_ORIGIN + GLYPH_H);
        w_yrel = int'(w_ny) - Y_ORIGIN;

        // Leading-zero blanking: slot k is dark when it and every digit above
        // it are zero. Digit 0 is excluded so a zero score still shows "0".
        w_zero_acc = 1'b1;
        w_blank    = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            w_zero_acc = w_zero_acc && (w_disp[k*BCD_W +: BCD_W] == 4'd0);
            if (C_IDX_W'(k) == w_slot) begin
                w_blank = w_zero_acc;
            end
        end

        w_v      = w_disp[int'(w_slot)*BCD_W +: BCD_W];
        w_addr_i = 0;
        if (w_hit_x && w_in_y) begin
            w_addr_i = int'(w_v) * C_PIX + w_yrel * GLYPH_W + w_xrel;
        end
        w_rom_addr = C_ADDR_W'(w_addr_i);
    end

    digit_glyph_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .ADDR_W  (C_ADDR_W)
    ) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .i_addr  (w_rom_addr),
        .o_dout  (w_rom_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_slot <= 1'b0;
            r_blank   <= 1'b0;
        end else begin
            r_in_slot <= w_hit_x && w_in_y;
            r_blank   <= w_blank;
        end
    end

    assign isFilled = w_rom_dout & r_in_slot & ~r_blank;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_bcd_display
// Purpose  : Directed self-checking bench for score_bcd_display (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_bcd_display;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_sub;
    logic [3:0]  cmd_amount;
    logic        game_clr;
    logic        show_hi;
    logic [15:0] score;
    logic [15:0] hi_score;
    logic        gameover;
    logic [11:0] x_p;
    logic [11:0] y_p;
    logic        isFilled;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_score = 16'h0;

    always #5 clk = ~clk;

    score_bcd_display #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sub    (cmd_sub),
        .cmd_amount (cmd_amount),
        .game_clr   (game_clr),
        .show_hi    (show_hi),
        .score      (score),
        .hi_score   (hi_score),
        .gameover   (gameover),
        .x_p        (x_p),
        .y_p        (y_p),
        .isFilled   (isFilled)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Issues one command and returns at the falling edge after the commit edge.
    task automatic do_cmd(input logic sub, input logic [3:0] amt,
                          input logic [15:0] exp_new, input bit detail);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_sub    = sub;
        cmd_amount = amt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 0; c < DIGITS + 1; c++) begin
            @(negedge clk);
            if (detail) begin
                check("busy_ready_low", cmd_ready, 0);
                check("score_hold", score, exp_score);
            end
        end
        @(negedge clk);
        check("score", score, exp_new);
        if (detail) check("ready_back", cmd_ready, 1);
        exp_score = exp_new;
    endtask

    task automatic do_clear();
        @(negedge clk);
        game_clr = 1'b1;
        @(negedge clk);
        game_clr  = 1'b0;
        exp_score = 16'h0;
        check("clr_score", score, 16'h0);
        check("clr_gameover", gameover, 0);
    endtask

    // Presents the pixel before (px,py) so isFilled describes (px,py) after the edge.
    task automatic pix(input string tag, input int px, input int py, input logic exp);
        @(negedge clk);
        x_p = 12'(px - 1);
        y_p = 12'(py);
        @(posedge clk);
        #1 check(tag, isFilled, exp);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_sub = 1'b0; cmd_amount = 4'd0;
        game_clr = 1'b0; show_hi = 1'b0; x_p = 12'd0; y_p = 12'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_score", score, 16'h0);
        check("rst_hi", hi_score, 16'h0);
        check("rst_gameover", gameover, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_isfilled", isFilled, 0);

        // add 7, add 5 with cycle-accurate busy window
        do_cmd(1'b0, 4'd7, 16'h0007, 1'b1);
        do_cmd(1'b0, 4'd5, 16'h0012, 1'b1);
        check("hi_0012", hi_score, 16'h0012);
        check("go_after_add", gameover, 0);

        // climb to 0100 (amount 15 clamps to 9), then borrow chains
        for (int i = 1; i <= 9; i++) do_cmd(1'b0, 4'd15, to_bcd(12 + 9*i), 1'b0);
        do_cmd(1'b0, 4'd7, 16'h0100, 1'b0);
        check("hi_0100", hi_score, 16'h0100);
        do_cmd(1'b1, 4'd1, 16'h0099, 1'b1);
        do_cmd(1'b1, 4'd9, 16'h0090, 1'b0);
        check("go_after_sub", gameover, 0);
        check("hi_kept_0100", hi_score, 16'h0100);

        // underflow and sticky game over
        do_clear();
        check("hi_after_clr", hi_score, 16'h0100);
        do_cmd(1'b1, 4'd0, 16'h0000, 1'b0);
        check("sub0_from0_no_go", gameover, 0);
        do_cmd(1'b0, 4'd3, 16'h0003, 1'b0);
        do_cmd(1'b1, 4'd5, 16'h0000, 1'b0);
        check("underflow_go", gameover, 1);
        do_cmd(1'b0, 4'd4, 16'h0000, 1'b0);
        check("go_sticky", gameover, 1);
        check("hi_after_go", hi_score, 16'h0100);

        // saturation
        do_clear();
        for (int i = 1; i <= 1110; i++) do_cmd(1'b0, 4'd9, to_bcd(9*i), 1'b0);
        do_cmd(1'b0, 4'd5, 16'h9995, 1'b0);
        do_cmd(1'b0, 4'd9, 16'h9999, 1'b0);
        check("hi_9999", hi_score, 16'h9999);
        check("go_after_sat", gameover, 0);

        // game_clr during the second CALC cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_sub = 1'b0; cmd_amount = 4'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 game_clr = 1'b1;
        @(posedge clk);
        #1;
        check("midclr_score", score, 16'h0000);
        check("midclr_hi", hi_score, 16'h9999);
        game_clr = 1'b0;
        #1 check("midclr_idle_ready", cmd_ready, 1);
        repeat (8) @(negedge clk);
        check("midclr_no_late_commit", score, 16'h0000);

        // clear wins over a simultaneous command
        game_clr = 1'b1; cmd_valid = 1'b1; cmd_amount = 4'd5;
        #1 check("clr_blocks_ready", cmd_ready, 0);
        @(negedge clk);
        game_clr = 1'b0; cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("clr_cmd_dropped", score, 16'h0000);
        exp_score = 16'h0;

        // a zero score still shows digit 0; higher slots are blank
        pix("zero_digit0_f", 745, 20, 1'b1);
        pix("zero_slot1_blank", 685, 20, 1'b0);

        // score 0042 readout
        for (int i = 1; i <= 4; i++) do_cmd(1'b0, 4'd9, to_bcd(9*i), 1'b0);
        do_cmd(1'b0, 4'd6, 16'h0042, 1'b0);
        pix("s3_blank", 565, 20, 1'b0);
        pix("s2_blank", 625, 20, 1'b0);
        pix("g4_b", 735, 20, 1'b1);
        pix("g4_a_off", 710, 5, 1'b0);
        pix("g4_g", 710, 40, 1'b1);
        pix("g4_f", 685, 20, 1'b1);
        pix("g4_e_off", 685, 60, 1'b0);
        pix("g2_a", 770, 5, 1'b1);
        pix("g2_c_off", 795, 60, 1'b0);
        pix("g2_e", 745, 60, 1'b1);
        pix("g2_b", 795, 20, 1'b1);
        pix("below_readout", 770, 85, 1'b0);
        pix("left_of_readout", 500, 20, 1'b0);
        @(negedge clk);
        x_p = 12'd799; y_p = 12'd599;
        @(posedge clk);
        #1 check("wrap_to_origin", isFilled, 0);

        // high-score readout (9999, nothing blanked)
        show_hi = 1'b1;
        pix("hi_s3_f", 565, 20, 1'b1);
        pix("hi_s2_g", 650, 40, 1'b1);
        pix("hi_s3_e_off", 565, 60, 1'b0);
        show_hi = 1'b0;
        pix("live_s3_blank", 565, 20, 1'b0);

        // asynchronous reset mid-command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_sub = 1'b0; cmd_amount = 4'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_score", score, 16'h0000);
        check("arst_hi", hi_score, 16'h0000);
        check("arst_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_no_commit", score, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
